posit_unpack_pipe: RTL and testbench
====================================

// Module: posit_unpack_pipe
// PURPOSE
//  Two-stage pipelined posit decoder: splits an N-bit posit into sign, regime k, exponent,
//  hidden-bit mantissa and a combined scale, plus NaR/zero flags.
//  Input side of the posit PPU, the counterpart of the output rounding/packing stage.
//  Valid/ready on both sides; full throughput of one operand per cycle.
// PARAMETERS
//  pFormat   posit_pkg::posit_format_e'(0)  posit format; N=posit_width(pFormat), ES=exp_bits(pFormat), RS=$clog2(N)
//  TagWidth  1                              width of the opaque sideband tag carried with each operand
// PORTS
//  clk_i         in   1            clock; all state updates on the rising edge
//  rst_ni        in   1            asynchronous, active-low reset
//  in_valid_i    in   1            operand valid
//  in_ready_o    out  1            block accepts an operand this cycle
//  operand_i     in   N            posit bit pattern
//  tag_i         in   TagWidth     sideband, returned unchanged with the result
//  out_valid_o   out  1            result valid
//  out_ready_i   in   1            downstream accepts the result
//  sign_o        out  1            posit sign
//  k_o           out  RS+1 signed  regime value
//  exp_o         out  ES           exponent field; truncated bits are read as 0
//  mant_o        out  N            mantissa: hidden 1 at bit N-1, fraction left-aligned below it
//  total_exp_o   out  RS+ES+5 s.   scale, k*2^ES + exp, sign-extended; same width as the packer's scale input
//  nar_o         out  1            operand was NaR (1 followed by zeros)
//  zero_o        out  1            operand was zero
//  tag_o         out  TagWidth     tag of this result
//  flush_i       in   1            present only with POSIT_UNPACK_FLUSH_EN
// BEHAVIOUR
//  Reset: async on rst_ni low. Both stage valids go to 0; all data registers go to 0.
//   Outputs read as 0. In-flight operands are discarded, including mid-operation.
//  Handshake: a transfer occurs when valid & ready are both high.
//   s2_rdy = ~s2_valid | out_ready_i;  s1_rdy = ~s1_valid | s2_rdy;  in_ready_o = s1_rdy.
//   While out_valid_o=1 and out_ready_i=0, all outputs hold stable.
//   Latency is 2 cycles from input accept to out_valid_o. No bubbles while out_ready_i=1.
//   Operands leave in acceptance order.
//  Stage 1 registers:
//   - sign = msb.
//   - nar = (operand == {1,0..}); zero = (operand == 0).
//   - body = operand[N-2:0], two's-complemented when sign=1.
//   - tag.
//  Stage 2 (sub-module posit_regime_count on the stage-1 body):
//   - Leading-run length m of bit body[N-2], counted over N-1 bits.
//   - k = body[N-2] ? m-1 : -m.
//   - Remainder = body << (m+1), zero-filled; a full-length run leaves the remainder 0.
//   - exp = remainder top ES bits; mant = {1, remainder[N-2-ES:0], 0-pad}.
//   - total_exp = (k <<< ES) + exp, signed.
//  When nar or zero: k=0, exp=0, mant=0, total_exp=0, sign=operand msb.
//  Stage-1 and stage-2 data registers load only on their accept; otherwise they hold.
// CONFIGURATION
//  POSIT_UNPACK_FLUSH_EN defined:
//   - Adds flush_i. When it is high, both stage valids clear at the next edge.
//   - in_ready_o is forced to 0 that cycle, so nothing is accepted.
//   - flush wins over simultaneous input and output handshakes; out_valid_o falls next cycle.
//  Undefined: no flush_i port; pipeline drains only through the handshake.
// STRUCTURE
//  posit_pkg: posit_format_e, posit_width(), exp_bits().
//   Add a posit_unpacked_t struct template (sign, k, exp, mant, total_exp, nar, zero),
//   shared with the packer.
//  One sub-module, posit_regime_count: combinational run-length counter, parameter N,
//   returns m and all-ones/all-zeros flag.
//  Pipeline registers and handshake stay in this module.
// TESTING  (16-bit, ES=1 format)
//  0x4000 -> sign0 k0 exp0 mant 0x8000 total 0. 0x4800 -> mant 0xC000, total 0.
//   0x5000 -> exp1, total 1.
//  0xC000 -> sign1 k0 exp0 mant 0x8000 total 0. 0x0000 -> zero=1. 0x8000 -> nar=1, other fields 0.
//  0x7FFF -> k=14, exp0, mant 0x8000, total 28. 0x0001 -> k=-14, total -28.
//  Stream 8 operands with out_ready_i=1 -> 8 results on 8 consecutive cycles, 2 cycles after each input.
//   Tags match input order.
//  Hold out_ready_i=0 and offer 3 operands -> 2 accepted, then in_ready_o=0 and outputs stable.
//   Release -> all 3 emerge in order.
//  rst_ni low mid-stream -> out_valid_o=0 immediately; after release, the first result is the next new operand.
//  With POSIT_UNPACK_FLUSH_EN: flush_i alongside in_valid_i -> no result appears for pipeline contents
//   or that operand.

Source files
------------

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - posit format table and unpacked-operand layout shared by the PPU stages
package posit_pkg;

   typedef enum logic [1:0] {
      POSIT16_ES1 = 2'd0,
      POSIT8_ES2  = 2'd1,
      POSIT32_ES2 = 2'd2
   } posit_format_e;

   function automatic int posit_width(posit_format_e fmt);
      case (fmt)
         POSIT8_ES2:  return 8;
         POSIT32_ES2: return 32;
         default:     return 16;
      endcase
   endfunction

   function automatic int exp_bits(posit_format_e fmt);
      case (fmt)
         POSIT8_ES2:  return 2;
         POSIT32_ES2: return 2;
         default:     return 1;
      endcase
   endfunction

   // Sized for the widest format; narrower formats occupy the low bits of each field.
   localparam int MAX_N  = 32;
   localparam int MAX_ES = 2;
   localparam int MAX_RS = 5;
   localparam int MAX_SW = MAX_RS + MAX_ES + 5;

   typedef struct packed {
      logic                     sign;
      logic signed [MAX_RS:0]   k;
      logic [MAX_ES-1:0]        exp;
      logic [MAX_N-1:0]         mant;
      logic signed [MAX_SW-1:0] total_exp;
      logic                     nar;
      logic                     zero;
   } posit_unpacked_t;

endpackage

// File: rtl/posit_regime_count.sv
// rtl/posit_regime_count.sv - leading-run length of the regime bit over an N-1 bit posit body
module posit_regime_count #(
   parameter  int N  = 16,
   localparam int RS = $clog2(N)
) (
   input  logic [N-2:0]  body,
   output logic [RS-1:0] run_len,
   output logic          uniform
);

   logic run;

   always_comb begin
      run_len = RS'(1);
      run     = 1'b1;
      for (int i = N - 3; i >= 0; i--) begin
         if (run && (body[i] == body[N-2])) begin
            run_len = run_len + RS'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   assign uniform = (run_len == RS'(N - 1));

endmodule

// File: rtl/posit_unpack_pipe.sv
// rtl/posit_unpack_pipe.sv - two-stage posit decoder with valid/ready; POSIT_UNPACK_FLUSH_EN adds flush_i
module posit_unpack_pipe
   import posit_pkg::*;
#(
   parameter  posit_format_e pFormat  = posit_format_e'(0),
   parameter  int            TagWidth = 1,
   localparam int            N        = posit_width(pFormat),
   localparam int            ES       = exp_bits(pFormat),
   localparam int            RS       = $clog2(N),
   localparam int            SW       = RS + ES + 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [N-1:0]         operand_i,
   input  logic [TagWidth-1:0]  tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 sign_o,
   output logic signed [RS:0]   k_o,
   output logic [ES-1:0]        exp_o,
   output logic [N-1:0]         mant_o,
   output logic signed [SW-1:0] total_exp_o,
   output logic                 nar_o,
   output logic                 zero_o,
   output logic [TagWidth-1:0]  tag_o
`ifdef POSIT_UNPACK_FLUSH_EN
   ,
   input  logic                 flush_i
`endif
);

   logic flush;
`ifdef POSIT_UNPACK_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   logic                s1_valid, s2_valid, s1_rdy, s2_rdy, s1_load, s2_load;
   logic                s1_sign, s1_nar, s1_zero;
   logic [N-2:0]        s1_body;
   logic [TagWidth-1:0] s1_tag;

   assign s2_rdy      = ~s2_valid | out_ready_i;
   assign s1_rdy      = ~s1_valid | s2_rdy;
   assign in_ready_o  = s1_rdy & ~flush;
   assign s1_load     = in_valid_i & in_ready_o;
   assign s2_load     = s1_valid & s2_rdy & ~flush;
   assign out_valid_o = s2_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_body  <= '0;
         s1_tag   <= '0;
      end else begin
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_rdy) begin
            s1_valid <= in_valid_i;
         end
         // Negative posits decode from the two's complement of the body.
         if (s1_load) begin
            s1_sign <= operand_i[N-1];
            s1_nar  <= (operand_i == {1'b1, {(N-1){1'b0}}});
            s1_zero <= (operand_i == '0);
            s1_body <= operand_i[N-1] ? -operand_i[N-2:0] : operand_i[N-2:0];
            s1_tag  <= tag_i;
         end
      end
   end

   logic [RS-1:0]        run_len;
   logic                 uniform;
   logic [N-2:0]         rem;
   logic signed [RS:0]   k_c;
   logic [ES-1:0]        exp_c;
   logic [N-1:0]         mant_c;
   logic signed [SW-1:0] scale_c;

   posit_regime_count #(.N(N)) u_regime (
      .body    (s1_body),
      .run_len (run_len),
      .uniform (uniform)
   );

   always_comb begin
      rem     = uniform ? '0 : (s1_body << (run_len + RS'(1)));
      k_c     = s1_body[N-2] ? {1'b0, run_len - RS'(1)} : -{1'b0, run_len};
      exp_c   = rem[N-2 -: ES];
      mant_c  = {1'b1, rem[N-2-ES:0], {ES{1'b0}}};
      scale_c = ({{(SW-RS-1){k_c[RS]}}, k_c} <<< ES) + SW'(exp_c);
      if (s1_nar || s1_zero) begin
         k_c     = '0;
         exp_c   = '0;
         mant_c  = '0;
         scale_c = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid    <= 1'b0;
         sign_o      <= 1'b0;
         k_o         <= '0;
         exp_o       <= '0;
         mant_o      <= '0;
         total_exp_o <= '0;
         nar_o       <= 1'b0;
         zero_o      <= 1'b0;
         tag_o       <= '0;
      end else begin
         if (flush) begin
            s2_valid <= 1'b0;
         end else if (s2_rdy) begin
            s2_valid <= s1_valid;
         end
         if (s2_load) begin
            sign_o      <= s1_sign;
            k_o         <= k_c;
            exp_o       <= exp_c;
            mant_o      <= mant_c;
            total_exp_o <= scale_c;
            nar_o       <= s1_nar;
            zero_o      <= s1_zero;
            tag_o       <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// tb/tb_posit_unpack_pipe.sv - self-checking bench for posit_unpack_pipe, 16-bit ES=1 format
module tb_posit_unpack_pipe;
   import posit_pkg::*;

   localparam int TW = 4;
   localparam int NV = 14;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [15:0]         operand = '0;
   logic [TW-1:0]       in_tag = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                sign;
   logic signed [4:0]   k;
   logic [0:0]          exp_f;
   logic [15:0]         mant;
   logic signed [9:0]   total;
   logic                nar, zero;
   logic [TW-1:0]       tag_out;
`ifdef POSIT_UNPACK_FLUSH_EN
   logic                flush = 1'b0;
`endif

   posit_unpack_pipe #(.pFormat(POSIT16_ES1), .TagWidth(TW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .operand_i   (operand),
      .tag_i       (in_tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sign_o      (sign),
      .k_o         (k),
      .exp_o       (exp_f),
      .mant_o      (mant),
      .total_exp_o (total),
      .nar_o       (nar),
      .zero_o      (zero),
      .tag_o       (tag_out)
`ifdef POSIT_UNPACK_FLUSH_EN
      ,
      .flush_i     (flush)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]       op;
      logic              sign;
      logic signed [4:0] k;
      logic              exp;
      logic [15:0]       mant;
      logic signed [9:0] total;
      logic              nar;
      logic              zero;
   } vec_t;

   typedef struct {
      vec_t          v;
      logic [TW-1:0] tag;
      int            cyc;
   } sb_t;

   vec_t tbl[NV];
   sb_t  sb[$];
   int   cur_idx = 0;
   int   cycle = 0;
   int   pass_cnt = 0;
   int   check_cnt = 0;
   bit   lat_chk = 1'b0;

   function automatic vec_t mk(logic [15:0] op, logic s, int kv, logic e, logic [15:0] m,
                               int t, logic n, logic z);
      vec_t v;
      v.op = op; v.sign = s; v.k = 5'(kv); v.exp = e; v.mant = m;
      v.total = 10'(t); v.nar = n; v.zero = z;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      check_cnt++;
      if (act === want) pass_cnt++;
      else $display("FAIL %s: got %h, want %h", name, act, want);
   endtask

   function automatic logic [63:0] dut_bundle();
      return 64'({sign, k, exp_f, mant, total, nar, zero, tag_out});
   endfunction

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious result", 64'(tag_out), 64'hDEAD);
            end else begin
               sb_t e;
               e = sb.pop_front();
               check($sformatf("result op=%h", e.v.op), dut_bundle(),
                     64'({e.v.sign, e.v.k, e.v.exp, e.v.mant, e.v.total, e.v.nar, e.v.zero, e.tag}));
               if (lat_chk) check($sformatf("latency op=%h", e.v.op), 64'(cycle - e.cyc), 64'd2);
            end
         end
         if (in_valid && in_ready) sb.push_back('{tbl[cur_idx], in_tag, cycle});
      end
   end

   task automatic present(input int idx);
      cur_idx  = idx;
      operand  = tbl[idx].op;
      in_tag   = in_tag + TW'(1);
      in_valid = 1'b1;
   endtask

   task automatic drive(input int idx);
      bit done = 1'b0;
      int n = 0;
      present(idx);
      while (!done && n < 50) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) check("drive timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] snap;
      bit          got;
      int          n;

      tbl[0]  = mk(16'h4000, 1'b0,   0, 1'b0, 16'h8000,   0, 1'b0, 1'b0);
      tbl[1]  = mk(16'h4800, 1'b0,   0, 1'b0, 16'hC000,   0, 1'b0, 1'b0);
      tbl[2]  = mk(16'h5000, 1'b0,   0, 1'b1, 16'h8000,   1, 1'b0, 1'b0);
      tbl[3]  = mk(16'hC000, 1'b1,   0, 1'b0, 16'h8000,   0, 1'b0, 1'b0);
      tbl[4]  = mk(16'h0000, 1'b0,   0, 1'b0, 16'h0000,   0, 1'b0, 1'b1);
      tbl[5]  = mk(16'h8000, 1'b1,   0, 1'b0, 16'h0000,   0, 1'b1, 1'b0);
      tbl[6]  = mk(16'h7FFF, 1'b0,  14, 1'b0, 16'h8000,  28, 1'b0, 1'b0);
      tbl[7]  = mk(16'h0001, 1'b0, -14, 1'b0, 16'h8000, -28, 1'b0, 1'b0);
      tbl[8]  = mk(16'h6000, 1'b0,   1, 1'b0, 16'h8000,   2, 1'b0, 1'b0);
      tbl[9]  = mk(16'h3000, 1'b0,  -1, 1'b1, 16'h8000,  -1, 1'b0, 1'b0);
      tbl[10] = mk(16'hB000, 1'b1,   0, 1'b1, 16'h8000,   1, 1'b0, 1'b0);
      tbl[11] = mk(16'h4C00, 1'b0,   0, 1'b0, 16'hE000,   0, 1'b0, 1'b0);
      tbl[12] = mk(16'h0003, 1'b0, -13, 1'b1, 16'h8000, -25, 1'b0, 1'b0);
      tbl[13] = mk(16'hFFFF, 1'b1, -14, 1'b0, 16'h8000, -28, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset outputs", dut_bundle(), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Whole table, back to back
      lat_chk = 1'b1;
      for (int i = 0; i < NV; i++) drive(i);
      wait_empty();

      // Stream of 8 random table entries
      for (int i = 0; i < 8; i++) drive(int'($urandom_range(NV - 1, 0)));
      wait_empty();

      // Backpressure: two accepted, third stalls with outputs frozen
      lat_chk = 1'b0;
      out_ready = 1'b0;
      drive(1);
      drive(2);
      present(3);
      @(negedge clk);
      check("stall out_valid", 64'(out_valid), 64'd1);
      snap = dut_bundle();
      for (int c = 0; c < 3; c++) begin
         check($sformatf("stall in_ready c%0d", c), 64'(in_ready), 64'd0);
         check($sformatf("stall hold c%0d", c), dut_bundle(), snap);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check("stall release accept", 64'(got), 64'd1);
      wait_empty();

      // Asynchronous reset mid-stream
      lat_chk = 1'b1;
      drive(6);
      drive(7);
      check("pre-reset out_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset out_valid", 64'(out_valid), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(10);
      wait_empty();

`ifdef POSIT_UNPACK_FLUSH_EN
      // Flush alongside a new operand discards everything
      lat_chk = 1'b0;
      out_ready = 1'b0;
      drive(0);
      drive(1);
      present(2);
      flush = 1'b1;
      @(negedge clk);
      check("flush in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      sb.delete();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("flush out_valid c%0d", c), 64'(out_valid), 64'd0);
      end
`endif

      check("final scoreboard empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running, want finished");
      $fatal(1);
   end

endmodule
